led_source_sel: RTL and testbench

- Upstream feeder for the 8-digit seven-segment scanner; drives its 32-bit display word.
- Selects one of four CPU debug values (PC, instruction, ALU result, memory read data) via a debounced "next" button.
- A debounced "hold" button freezes a snapshot of all four values so they can be browsed while the CPU keeps running.

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_source_sel_if.sv | 29 ++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/led_source_sel.sv | 101 ++++++++++
 tb/tb_led_source_sel.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types for the display-source selector.
//   src_e   : which CPU debug value is shown (PC, instruction, ALU, memory).
//   hold_e  : freeze state. LIVE shows current values, FROZEN shows snapshots.
//   N_SRC   : number of selectable sources.
//   next_src: advances the source index, wrapping from SRC_MEM to SRC_PC.
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int N_SRC = 4;

  typedef enum logic [1:0] {
    SRC_PC    = 2'd0,
    SRC_INSTR = 2'd1,
    SRC_ALU   = 2'd2,
    SRC_MEM   = 2'd3
  } src_e;

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } hold_e;

  // The 2-bit add wraps 3 -> 0 naturally.
  function automatic src_e next_src(input src_e s);
    logic [1:0] n;
    n = s + 2'd1;
    return src_e'(n);
  endfunction

endpackage

// File: rtl/led_source_sel_if.sv
// ---------------------------------------------------------------------------
// led_source_sel_if
// Bundles the CPU debug values going into the selector and the display word
// and status coming out of it.
//   pc, instr, alu_result, mem_rdata : live 32-bit CPU debug values
//   out_data                         : registered 32-bit word for the scanner
//   src_idx                          : currently selected source
//   hold_active                      : 1 while the snapshot is frozen
// master = CPU/debug side, slave = led_source_sel.
// ---------------------------------------------------------------------------
interface led_source_sel_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic [1:0]  src_idx;
  logic        hold_active;

  modport master (
    output pc, instr, alu_result, mem_rdata,
    input  out_data, src_idx, hold_active
  );

  modport slave (
    input  pc, instr, alu_result, mem_rdata,
    output out_data, src_idx, hold_active
  );
endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw asynchronous button and accepts a new level only after
// it has differed from the accepted level for DEBOUNCE_CYCLES consecutive
// cycles. Emits a one-cycle pulse on every accepted rising edge.
//   clk, rst    : clock, asynchronous active-high reset
//   raw         : raw button input
//   level       : debounced level
//   press_pulse : 1-cycle pulse, cycle after level rises
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;                 // any agreement restarts the count
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign level       = deb_q;
  assign press_pulse = deb_q & ~deb_prev_q;

endmodule

// File: rtl/led_source_sel.sv
// ---------------------------------------------------------------------------
// led_source_sel
// Picks one of four CPU debug values for the seven-segment scanner. A
// debounced "next" button steps through the sources; a debounced "hold"
// button toggles between showing live values and a frozen snapshot.
//   clk, rst : clock, asynchronous active-high reset
//   btn_next : raw button, advances src_idx (mod 4) on each press
//   btn_hold : raw button, toggles LIVE/FROZEN on each press
//   dbg      : live CPU values in; out_data / src_idx / hold_active out
// ---------------------------------------------------------------------------
module led_source_sel
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_hold,
  led_source_sel_if.slave   dbg
);

  logic next_pulse, hold_pulse;
  // Debounced levels are not needed here; only the press pulses are.
  logic next_level_unused, hold_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_next),
    .level       (next_level_unused),
    .press_pulse (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
    .clk         (clk),
    .rst         (rst),
    .raw         (btn_hold),
    .level       (hold_level_unused),
    .press_pulse (hold_pulse)
  );

  hold_e                   state_q, state_d;
  src_e                    src_q, src_d;
  logic [N_SRC-1:0][31:0]  snap_q, snap_d;
  logic [31:0]             out_q, out_d;
  logic [N_SRC-1:0][31:0]  live;

  // Index 0 = PC, matching the src_e encoding.
  assign live = {dbg.mem_rdata, dbg.alu_result, dbg.instr, dbg.pc};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LIVE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LIVE:    if (hold_pulse) state_d = FROZEN;
      FROZEN:  if (hold_pulse) state_d = LIVE;
      default: state_d = LIVE;
    endcase
  end

  // Output logic.
  always_comb begin
    dbg.hold_active = (state_q == FROZEN);
  end

  // Datapath: source index, snapshot capture and output mux.
  always_comb begin
    src_d  = next_pulse ? next_src(src_q) : src_q;
    snap_d = snap_q;
    if (state_q == LIVE && hold_pulse) snap_d = live;
    // Only a cycle that stays FROZEN shows the snapshot; on entry the live
    // value being captured is identical to it.
    if (state_q == FROZEN && state_d == FROZEN) out_d = snap_q[src_d];
    else                                        out_d = live[src_d];
  end

  // NOTE: the snapshot registers are cleared on reset along with everything
  // else, so a FROZEN view never exposes stale power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= SRC_PC;
      snap_q <= '0;
      out_q  <= '0;
    end else begin
      src_q  <= src_d;
      snap_q <= snap_d;
      out_q  <= out_d;
    end
  end

  assign dbg.out_data = out_q;
  assign dbg.src_idx  = src_q;

endmodule

// File: tb/tb_led_source_sel.sv
// ---------------------------------------------------------------------------
// tb_led_source_sel
// Directed scenarios plus randomized button/CPU activity for led_source_sel,
// compared every cycle against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_led_source_sel;

  localparam int D = 4;

  logic clk;
  logic rst;
  logic btn_next;
  logic btn_hold;

  led_source_sel_if dbg();

  led_source_sel #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_hold (btn_hold),
    .dbg      (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button level is accepted once the raw samples it saw (two cycles of
  // synchroniser delay) have disagreed with the accepted level for D edges
  // running, counted from the later of reset and the previous acceptance.
  // An accepted rise acts on the following edge.
  int          m_src;
  bit          m_frozen;
  logic [31:0] m_snap [4];
  logic [31:0] m_out;
  bit          m_deb   [2];
  bit          m_rise  [2];
  int          m_since [2];
  bit          m_hist  [2][D+2];   // raw samples, [D+1] = newest edge

  task automatic model_reset();
    m_src = 0;
    m_frozen = 1'b0;
    m_out = '0;
    for (int i = 0; i < 4; i++) m_snap[i] = '0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b] = 1'b0;
      m_rise[b] = 1'b0;
      m_since[b] = 0;
      for (int j = 0; j < D + 2; j++) m_hist[b][j] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] live [4];
    bit          raw  [2];
    bit          frz_n, all_diff;
    int          idx_n;
    live[0] = dbg.pc;
    live[1] = dbg.instr;
    live[2] = dbg.alu_result;
    live[3] = dbg.mem_rdata;
    raw[0]  = btn_next;
    raw[1]  = btn_hold;

    idx_n = (m_src + (m_rise[0] ? 1 : 0)) % 4;
    frz_n = m_frozen ^ m_rise[1];
    if (m_frozen && frz_n) m_out = m_snap[idx_n];
    else                   m_out = live[idx_n];
    if (!m_frozen && m_rise[1]) m_snap = live;
    m_src    = idx_n;
    m_frozen = frz_n;

    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < D + 1; j++) m_hist[b][j] = m_hist[b][j+1];
      m_hist[b][D+1] = raw[b];
      m_since[b]++;
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (m_hist[b][j] == m_deb[b]) all_diff = 1'b0;
      m_rise[b] = 1'b0;
      if (all_diff && m_since[b] >= D) begin
        m_deb[b]   = ~m_deb[b];
        m_since[b] = 0;
        m_rise[b]  = m_deb[b];
      end
    end
  endtask

  task automatic check_model();
    check("out_data", dbg.out_data, m_out);
    check("src_idx", 32'(dbg.src_idx), 32'(m_src));
    check("hold_active", 32'(dbg.hold_active), 32'(m_frozen));
  endtask

  // One clock: model steps on the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic press(input bit which);
    if (which) btn_hold = 1'b1; else btn_next = 1'b1;
    repeat (D + 4) cycle();
    if (which) btn_hold = 1'b0; else btn_next = 1'b0;
    repeat (D + 4) cycle();
  endtask

  int seg_left [2];

  initial begin
    rst = 1'b1;
    btn_next = 1'b0;
    btn_hold = 1'b0;
    dbg.pc = 32'h0040_0000;
    dbg.instr = 32'h0000_0000;
    dbg.alu_result = 32'h0000_0000;
    dbg.mem_rdata = 32'h0000_0000;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out", dbg.out_data, 32'h0);
    check("reset_src", 32'(dbg.src_idx), 32'd0);
    check("reset_hold", 32'(dbg.hold_active), 32'd0);

    // 1: first edge after reset release shows live PC.
    rst = 1'b0;
    cycle();
    check("t1_out_pc", dbg.out_data, 32'h0040_0000);

    // 2: single advance despite a long press; latency D+3 edges.
    dbg.instr = 32'h8C08_0004;
    btn_next = 1'b1;
    repeat (D + 2) cycle();
    check("t2_src_before", 32'(dbg.src_idx), 32'd0);
    cycle();
    check("t2_src_edge7", 32'(dbg.src_idx), 32'd1);
    check("t2_out_instr", dbg.out_data, 32'h8C08_0004);
    repeat (20 - (D + 3)) cycle();
    check("t2_single_adv", 32'(dbg.src_idx), 32'd1);
    btn_next = 1'b0;
    repeat (D + 4) cycle();
    repeat (3) press(1'b0);
    check("t2_wrap", 32'(dbg.src_idx), 32'd0);

    // 3: glitches shorter than D never register.
    for (int len = 1; len <= D - 1; len++) begin
      btn_next = 1'b1;
      repeat (len) cycle();
      btn_next = 1'b0;
      repeat (3) cycle();
    end
    check("t3_glitch", 32'(dbg.src_idx), 32'd0);

    // 4: freeze, browse snapshot, unfreeze.
    press(1'b0);
    press(1'b0);
    dbg.alu_result = 32'h0000_002A;
    dbg.mem_rdata  = 32'hDEAD_BEEF;
    press(1'b1);
    dbg.alu_result = 32'h1111_1111;
    dbg.mem_rdata  = 32'h2222_2222;
    cycle();
    check("t4_frozen", 32'(dbg.hold_active), 32'd1);
    check("t4_snap_alu", dbg.out_data, 32'h0000_002A);
    press(1'b0);
    check("t4_snap_mem", dbg.out_data, 32'hDEAD_BEEF);
    press(1'b1);
    check("t4_live", 32'(dbg.hold_active), 32'd0);
    check("t4_live_mem", dbg.out_data, 32'h2222_2222);

    // 5: next and hold pressed together.
    press(1'b0);
    dbg.instr = 32'hAAAA_5555;
    btn_next = 1'b1;
    btn_hold = 1'b1;
    repeat (D + 3) cycle();
    check("t5_src", 32'(dbg.src_idx), 32'd1);
    check("t5_hold", 32'(dbg.hold_active), 32'd1);
    check("t5_out", dbg.out_data, 32'hAAAA_5555);
    dbg.instr = 32'h1234_5678;
    cycle();
    check("t5_snap", dbg.out_data, 32'hAAAA_5555);
    btn_next = 1'b0;
    btn_hold = 1'b0;
    repeat (D + 4) cycle();

    // 6: reset pulse mid-debounce while FROZEN.
    btn_next = 1'b1;
    repeat (4) cycle();
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_out", dbg.out_data, 32'h0);
    check("t6_rst_src", 32'(dbg.src_idx), 32'd0);
    check("t6_rst_hold", 32'(dbg.hold_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (D + 2) cycle();
    check("t6_no_early", 32'(dbg.src_idx), 32'd0);
    cycle();
    check("t6_accept", 32'(dbg.src_idx), 32'd1);
    btn_next = 1'b0;
    repeat (D + 4) cycle();

    // Randomized activity against the model.
    seg_left[0] = 0;
    seg_left[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 2; b++) begin
        if (seg_left[b] == 0) begin
          if (b == 0) btn_next = ~btn_next; else btn_hold = ~btn_hold;
          seg_left[b] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, D - 1))
                                                    : int'($urandom_range(D + 1, 12));
        end
        seg_left[b]--;
      end
      case ($urandom_range(0, 7))
        0: dbg.pc         = $urandom;
        1: dbg.instr      = $urandom;
        2: dbg.alu_result = $urandom;
        3: dbg.mem_rdata  = $urandom;
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
